// File: rtl/ysyx_22041752_memu_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load FSM
// state encodings and mem_bytes encodings.
package ysyx_22041752_memu_pkg;

    localparam int PKG_PC_WD         = 64;
    localparam int ES_TO_MS_BUS_WD   = 75 + PKG_PC_WD;
    localparam int MS_TO_WS_BUS_WD   = 70 + PKG_PC_WD;
    localparam int MS_FORWARD_BUS_WD = 71;

    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_WAIT = 2'd1;
    localparam logic [1:0] MS_HOLD = 2'd2;

    localparam logic [1:0] MEM_BYTE  = 2'b00;
    localparam logic [1:0] MEM_HALF  = 2'b01;
    localparam logic [1:0] MEM_WORD  = 2'b10;
    localparam logic [1:0] MEM_DWORD = 2'b11;

endpackage

// File: rtl/ysyx_22041752_load_ext.sv
// Load data alignment and extension: shifts the raw doubleword down to the
// addressed byte, then zero- or sign-extends the selected width.
module ysyx_22041752_load_ext
    import ysyx_22041752_memu_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [2:0]  offset,
    input  logic [1:0]  bytes,
    input  logic        zext,
    output logic [63:0] result
);

    logic [63:0] shifted;

    assign shifted = raw >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        case (bytes)
            MEM_BYTE:  result = {{56{~zext & shifted[7]}},  shifted[7:0]};
            MEM_HALF:  result = {{48{~zext & shifted[15]}}, shifted[15:0]};
            MEM_WORD:  result = {{32{~zext & shifted[31]}}, shifted[31:0]};
            MEM_DWORD: result = shifted;
            default:   result = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22041752_memu.sv
// Memory-access pipeline stage: payload register, load-response FSM and
// forwarding bus. YSYX_22041752_MEMU_DEBUG_EN adds difftest debug ports.
module ysyx_22041752_memu
    import ysyx_22041752_memu_pkg::*;
#(
    parameter int PC_WD      = 64,
    parameter int RF_DATA_WD = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ws_allowin,
    output logic                         ms_allowin,
    input  logic                         es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
    input  logic                         data_sram_rvalid,
    input  logic [63:0]                  data_sram_rdata,
    output logic                         ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
    output logic [MS_FORWARD_BUS_WD-1:0] ms_forward_bus
`ifdef YSYX_22041752_MEMU_DEBUG_EN
    ,
    output logic [PC_WD-1:0]             debug_ms_pc,
    output logic                         debug_ms_load_done
`endif
);

    localparam int ALU_LSB = PC_WD;
    localparam int RD_LSB  = PC_WD + RF_DATA_WD;
    localparam int WE_BIT  = RD_LSB + 5;
    localparam int RE_BIT  = WE_BIT + 1;
    localparam int MB_LSB  = RE_BIT + 1;
    localparam int ZX_BIT  = MB_LSB + 2;
    localparam int SX_BIT  = ZX_BIT + 1;

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
    logic [1:0]                 state;
    logic [63:0]                rdata_buf;

    logic [PC_WD-1:0]      ms_pc;
    logic [RF_DATA_WD-1:0] alu_result;
    logic [4:0]            rd;
    logic                  rf_we;
    logic                  mem_re;
    logic [1:0]            mem_bytes;
    logic                  res_zext;
    logic                  unused_res_sext;

    logic                  ms_ready_go;
    logic                  accept;
    logic                  in_mem_re;
    logic [63:0]           load_raw;
    logic [63:0]           load_value;
    logic [RF_DATA_WD-1:0] final_result;
    logic                  load_pending;
    logic                  fwd_valid;

    assign ms_pc           = es_bus_r[PC_WD-1:0];
    assign alu_result      = es_bus_r[ALU_LSB +: RF_DATA_WD];
    assign rd              = es_bus_r[RD_LSB +: 5];
    assign rf_we           = es_bus_r[WE_BIT];
    assign mem_re          = es_bus_r[RE_BIT];
    assign mem_bytes       = es_bus_r[MB_LSB +: 2];
    assign res_zext        = es_bus_r[ZX_BIT];
    // res_sext travels with the payload but loads extend by res_zext alone.
    assign unused_res_sext = es_bus_r[SX_BIT];
    assign in_mem_re       = es_to_ms_bus[RE_BIT];

    always_comb begin
        ms_ready_go = 1'b1;
        if (mem_re) begin
            case (state)
                MS_WAIT: ms_ready_go = data_sram_rvalid;
                MS_HOLD: ms_ready_go = 1'b1;
                default: ms_ready_go = 1'b0;
            endcase
        end
    end

    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign accept         = es_to_ms_valid && ms_allowin;
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            es_bus_r <= es_to_ms_bus;
        end
    end

    // A load leaving WAIT while write-back is blocked parks its data in HOLD;
    // rvalid outside WAIT never belongs to the current payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MS_IDLE;
            rdata_buf <= 64'd0;
        end else if (accept) begin
            state <= in_mem_re ? MS_WAIT : MS_IDLE;
        end else begin
            case (state)
                MS_WAIT: begin
                    if (data_sram_rvalid) begin
                        if (ws_allowin) begin
                            state <= MS_IDLE;
                        end else begin
                            state     <= MS_HOLD;
                            rdata_buf <= data_sram_rdata;
                        end
                    end
                end
                MS_HOLD: begin
                    if (ws_allowin) begin
                        state <= MS_IDLE;
                    end
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

    assign load_raw = (state == MS_HOLD) ? rdata_buf : data_sram_rdata;

    ysyx_22041752_load_ext u_load_ext (
        .raw    (load_raw),
        .offset (alu_result[2:0]),
        .bytes  (mem_bytes),
        .zext   (res_zext),
        .result (load_value)
    );

    assign final_result = mem_re ? load_value : alu_result;
    assign fwd_valid    = ms_valid && rf_we;
    assign load_pending = ms_valid && mem_re && (state == MS_WAIT) && !data_sram_rvalid;

    assign ms_to_ws_bus   = {rf_we, rd, final_result, ms_pc};
    assign ms_forward_bus = {load_pending, fwd_valid, final_result, rd};

`ifdef YSYX_22041752_MEMU_DEBUG_EN
    assign debug_ms_pc        = ms_pc;
    assign debug_ms_load_done = ms_valid && mem_re && ws_allowin &&
                                (((state == MS_WAIT) && data_sram_rvalid) || (state == MS_HOLD));
`endif

endmodule
